// File: rtl/fma_dot_pipe.sv
// fma_dot_pipe: pipelined LANES-wide signed fixed-point dot product with
// cross-beat accumulation, optional seed, rounding and saturation.
// Stages: S1 products, S2 adder tree, S3 accumulate, then output conversion.
module fma_dot_pipe #(
    parameter int WIDTH       = 16,
    parameter int FIXED_POINT = 10,
    parameter int LANES       = 4,
    parameter int SATURATE    = 1,
    parameter int GUARD       = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [LANES*WIDTH-1:0]   a_in,
    input  logic [LANES*WIDTH-1:0]   b_in,
    input  logic [WIDTH-1:0]         c_in,
    input  logic                     c_load_in,
    input  logic                     last_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic [WIDTH-1:0]         out,
    output logic                     ovf_out,
    output logic                     valid_out,
    input  logic                     out_ready_in
);

    localparam int ACC_W = 2*WIDTH + GUARD;
    localparam int R_W   = ACC_W - FIXED_POINT;

    localparam logic [ACC_W-1:0]      HALF  = ACC_W'(1) << (FIXED_POINT-1);
    localparam logic signed [R_W-1:0] R_MAX = {{(R_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [R_W-1:0] R_MIN = {{(R_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]      O_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]      O_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic signed [2*WIDTH-1:0] sext_prod(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] sext_acc(input logic [2*WIDTH-1:0] v);
        return {{(ACC_W-2*WIDTH){v[2*WIDTH-1]}}, v};
    endfunction

    // Global stall: everything freezes while a result waits on the consumer.
    logic adv;
    logic accept;
    assign adv       = !(valid_out && !out_ready_in);
    assign ready_out = adv;
    assign accept    = valid_in && adv;

    // ---------------- S1: lane products ----------------
    logic signed [2*WIDTH-1:0] prod [LANES];
    logic signed [2*WIDTH-1:0] s1_p [LANES];
    logic                      s1_valid, s1_c_load, s1_last;
    logic [WIDTH-1:0]          s1_c;

    // Full-precision signed product per lane (Q.2F).
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i] = sext_prod(a_in[i*WIDTH +: WIDTH]) * sext_prod(b_in[i*WIDTH +: WIDTH]);
        end
    end

    // S1 valid; a bubble enters whenever nothing is accepted.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)   s1_valid <= 1'b0;
        else if (adv) s1_valid <= valid_in;
    end

    // S1 payload captured on accept.
    // NOTE: datapath payload is not reset; its matching valid bit qualifies it.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            s1_p      <= prod;
            s1_c_load <= c_load_in;
            s1_last   <= last_in;
            s1_c      <= c_in;
        end
    end

    // ---------------- S2: adder tree ----------------
    logic [ACC_W-1:0] tree_sum;
    logic [ACC_W-1:0] s2_sum;
    logic             s2_valid, s2_c_load, s2_last;
    logic [WIDTH-1:0] s2_c;

    // Sign-extended sum of all lane products.
    // NOTE: combinational outputs get a default before any conditional or loop, so no latch is inferred.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + sext_acc(s1_p[i]);
        end
    end

    // S2 valid follows S1 when the pipe advances.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)   s2_valid <= 1'b0;
        else if (adv) s2_valid <= s1_valid;
    end

    // S2 payload: beat sum plus forwarded flags.
    always_ff @(posedge clk_in) begin
        if (adv && s1_valid) begin
            s2_sum    <= tree_sum;
            s2_c_load <= s1_c_load;
            s2_last   <= s1_last;
            s2_c      <= s1_c;
        end
    end

    // ---------------- S3: accumulate ----------------
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] s3_res;
    logic             s3_valid;

    // Seed (c aligned to Q.2F) or running accumulator, plus this beat's sum.
    always_comb begin
        acc_base = acc;
        if (s2_c_load) acc_base = {{(ACC_W-WIDTH){s2_c[WIDTH-1]}}, s2_c} << FIXED_POINT;
        acc_next = acc_base + s2_sum;
    end

    // Accumulator clears at vector end so the next vector starts from zero.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc      <= '0;
            s3_valid <= 1'b0;
        end else if (adv) begin
            s3_valid <= s2_valid && s2_last;
            if (s2_valid) acc <= s2_last ? '0 : acc_next;
        end
    end

    // Final unrounded vector total awaiting conversion.
    always_ff @(posedge clk_in) begin
        if (adv && s2_valid && s2_last) s3_res <= acc_next;
    end

    // ---------------- Output conversion ----------------
    logic [ACC_W-1:0]      rounded;
    logic signed [R_W-1:0] r;
    logic [WIDTH-1:0]      conv;
    logic                  conv_ovf;

    // Round half toward +inf, then clamp or wrap to WIDTH bits.
    always_comb begin
        rounded  = s3_res + HALF;
        r        = rounded[ACC_W-1:FIXED_POINT];
        conv     = r[WIDTH-1:0];
        conv_ovf = 1'b0;
        if (SATURATE != 0) begin
            if (r > R_MAX) begin
                conv     = O_MAX;
                conv_ovf = 1'b1;
            end else if (r < R_MIN) begin
                conv     = O_MIN;
                conv_ovf = 1'b1;
            end
        end else begin
            conv_ovf = (r != {{(R_W-WIDTH){conv[WIDTH-1]}}, conv});
        end
    end

    // Output register: loads a new result or clears on take; frozen while stalled.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            out       <= '0;
            ovf_out   <= 1'b0;
        end else if (adv) begin
            valid_out <= s3_valid;
            if (s3_valid) begin
                out     <= conv;
                ovf_out <= conv_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fma_dot_pipe.sv
// Testbench for fma_dot_pipe: directed vectors with literal expectations and a
// longint reference model checked against the output every valid cycle.
module tb_fma_dot_pipe;

    localparam int W = 16;
    localparam int F = 10;
    localparam int L = 4;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [L*W-1:0]   a_in, b_in;
    logic [W-1:0]     c_in;
    logic             c_load_in, last_in, valid_in;
    logic             ready_out;
    logic [W-1:0]     out;
    logic             ovf_out, valid_out;
    logic             out_ready_in;

    fma_dot_pipe #(
        .WIDTH(W), .FIXED_POINT(F), .LANES(L), .SATURATE(1), .GUARD(8)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .c_load_in(c_load_in), .last_in(last_in), .valid_in(valid_in),
        .ready_out(ready_out),
        .out(out), .ovf_out(ovf_out), .valid_out(valid_out),
        .out_ready_in(out_ready_in)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] val;
        logic         ovf;
    } res_t;

    res_t         exp_q[$];
    logic [W-1:0] taken_log[$];
    longint       m_acc = 0;

    function automatic longint lane(input logic [L*W-1:0] v, input int i);
        logic signed [W-1:0] x;
        x = v[i*W +: W];
        return longint'(x);
    endfunction

    function automatic res_t model_convert(input longint v);
        longint r, hi, lo;
        res_t   res;
        hi = (longint'(1) <<< (W-1)) - 1;
        lo = -(longint'(1) <<< (W-1));
        r  = (v + (longint'(1) <<< (F-1))) >>> F;
        if (r > hi) begin
            res.val = hi[W-1:0];
            res.ovf = 1'b1;
        end else if (r < lo) begin
            res.val = lo[W-1:0];
            res.ovf = 1'b1;
        end else begin
            res.val = r[W-1:0];
            res.ovf = 1'b0;
        end
        return res;
    endfunction

    // Compare the output against the model whenever it is valid, then update the model.
    always @(negedge clk_in) begin : model_cmp
        longint     dot, nxt;
        logic signed [W-1:0] cs;
        if (rst_in) begin
            exp_q.delete();
            m_acc = 0;
        end else begin
            if (valid_out) begin
                check("model_result_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("model_out", {16'b0, out}, {16'b0, exp_q[0].val});
                    check("model_ovf", {31'b0, ovf_out}, {31'b0, exp_q[0].ovf});
                    if (out_ready_in) begin
                        taken_log.push_back(out);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (valid_in && ready_out) begin
                dot = 0;
                for (int i = 0; i < L; i++) dot += lane(a_in, i) * lane(b_in, i);
                cs  = c_in;
                nxt = (c_load_in ? (longint'(cs) <<< F) : m_acc) + dot;
                if (last_in) begin
                    exp_q.push_back(model_convert(nxt));
                    m_acc = 0;
                end else begin
                    m_acc = nxt;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [L*W-1:0] pack4(input logic [W-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic align();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        valid_in  = 1'b0;
        last_in   = 1'b0;
        c_load_in = 1'b0;
    endtask

    // Present a beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                             input logic [W-1:0] c, input logic cl, input logic last);
        logic ok;
        int   cnt;
        a_in = a; b_in = b; c_in = c; c_load_in = cl; last_in = last; valid_in = 1'b1;
        ok = 1'b0;
        cnt = 0;
        while (!ok && cnt < 200) begin
            @(negedge clk_in);
            ok = ready_out;
            @(posedge clk_in);
            #1;
            cnt++;
        end
        check("send_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_result(input string name, input logic [W-1:0] exp_val, input logic exp_ovf);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk_in);
            cnt++;
        end while (!valid_out && cnt < 20);
        check({name, "_valid"}, {31'b0, valid_out}, 32'd1);
        check({name, "_out"}, {16'b0, out}, {16'b0, exp_val});
        check({name, "_ovf"}, {31'b0, ovf_out}, {31'b0, exp_ovf});
    endtask

    logic [L*W-1:0] zero_v;
    logic           stream_done;
    int             n0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_v = '0;
        rst_in = 1'b1; out_ready_in = 1'b1;
        a_in = '0; b_in = '0; c_in = '0;
        c_load_in = 1'b0; last_in = 1'b0; valid_in = 1'b0;
        stream_done = 1'b0;

        // Reset state
        #1;
        check("reset_valid_out", {31'b0, valid_out}, 32'd0);
        check("reset_out", {16'b0, out}, 32'd0);
        check("reset_ovf", {31'b0, ovf_out}, 32'd0);
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        #1 check("reset_ready", {31'b0, ready_out}, 32'd1);

        // 1: single beat 2.0*1.5 + 1.0*3.0 = 6.0, latency of three edges
        align();
        send_beat(pack4(16'h0800, 16'h0400, 16'h0, 16'h0),
                  pack4(16'h0600, 16'h0C00, 16'h0, 16'h0), 16'h0, 1'b1, 1'b1);
        idle();
        repeat (3) @(negedge clk_in);
        check("t1_not_early", {31'b0, valid_out}, 32'd0);
        @(negedge clk_in);
        check("t1_valid", {31'b0, valid_out}, 32'd1);
        check("t1_out", {16'b0, out}, 32'h1800);
        check("t1_ovf", {31'b0, ovf_out}, 32'd0);

        // 2: two beats with seed 1.0: 1 + 3 + 3 = 7.0
        align();
        send_beat(pack4(16'h0800, 16'h0, 16'h0, 16'h0), pack4(16'h0600, 16'h0, 16'h0, 16'h0),
                  16'h0400, 1'b1, 1'b0);
        send_beat(pack4(16'h0400, 16'h0, 16'h0, 16'h0), pack4(16'h0C00, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b0, 1'b1);
        idle();
        wait_result("t2", 16'h1C00, 1'b0);

        // 3: positive and negative saturation
        align();
        send_beat(pack4(16'h1480, 16'h0, 16'h0, 16'h0), pack4(16'h1800, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b1, 1'b0);
        send_beat(pack4(16'h0800, 16'h0, 16'h0, 16'h0), pack4(16'h0600, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b0, 1'b1);
        idle();
        wait_result("t3_pos", 16'h7FFF, 1'b1);
        align();
        send_beat(pack4(16'hE000, 16'h0, 16'h0, 16'h0), pack4(16'h2000, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b1, 1'b1);
        idle();
        wait_result("t3_neg", 16'h8000, 1'b1);

        // 4: rounding at exactly half an LSB, and the largest value that fits
        align();
        send_beat(pack4(16'h0001, 16'h0, 16'h0, 16'h0), pack4(16'h0200, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b0, 1'b1);
        idle();
        wait_result("t4_pos_half", 16'h0001, 1'b0);
        align();
        send_beat(pack4(16'hFFFF, 16'h0, 16'h0, 16'h0), pack4(16'h0200, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b0, 1'b1);
        idle();
        wait_result("t4_neg_half", 16'h0000, 1'b0);
        align();
        send_beat(pack4(16'h7FFF, 16'h0, 16'h0, 16'h0), pack4(16'h0400, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b1, 1'b1);
        idle();
        wait_result("t4_max", 16'h7FFF, 1'b0);

        // 5: backpressure, then 8 beats under random consumer stalls
        align();
        out_ready_in = 1'b0;
        n0 = taken_log.size();
        send_beat(pack4(16'h0400, 16'h0, 16'h0, 16'h0), pack4(16'h0400, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b1, 1'b1);
        idle();
        wait_result("t5_pend", 16'h0400, 1'b0);
        check("t5_ready_low", {31'b0, ready_out}, 32'd0);
        repeat (3) begin
            @(negedge clk_in);
            check("t5_frozen_valid", {31'b0, valid_out}, 32'd1);
            check("t5_frozen_out", {16'b0, out}, 32'h0400);
        end
        align();
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        idle();
                        align();
                    end
                    if (k < 4)
                        send_beat({4{16'h0400}}, pack4(16'h0200, 16'h0100, 16'h0080, 16'h0040),
                                  16'h0, k == 0, k == 3);
                    else
                        send_beat({4{16'h0800}}, pack4(16'hFC00, 16'h0, 16'h0, 16'h0100),
                                  16'h0400, k == 4, k == 7);
                end
                idle();
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk_in);
                    #1;
                    out_ready_in = 1'($urandom_range(0, 1));
                end
                out_ready_in = 1'b1;
            end
        join
        for (int cnt = 0; cnt < 100 && exp_q.size() != 0; cnt++) @(negedge clk_in);
        check("t5_drained", exp_q.size(), 32'd0);
        check("t5_result_count", taken_log.size() - n0, 32'd3);
        check("t5_res0", {16'b0, taken_log[n0]}, 32'h0400);
        check("t5_res1", {16'b0, taken_log[n0+1]}, 32'h0F00);
        check("t5_res2", {16'b0, taken_log[n0+2]}, 32'hEC00);

        // 6: async reset mid-vector with a result pending
        align();
        out_ready_in = 1'b0;
        send_beat(pack4(16'h1000, 16'h0, 16'h0, 16'h0), pack4(16'h0400, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b1, 1'b1);
        send_beat(pack4(16'h0800, 16'h0, 16'h0, 16'h0), pack4(16'h0600, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b1, 1'b0);
        send_beat(pack4(16'h0400, 16'h0, 16'h0, 16'h0), pack4(16'h0C00, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b0, 1'b0);
        idle();
        wait_result("t6_pend", 16'h1000, 1'b0);
        #2 rst_in = 1'b1;
        #1;
        check("t6_rst_valid", {31'b0, valid_out}, 32'd0);
        check("t6_rst_out", {16'b0, out}, 32'd0);
        check("t6_rst_ovf", {31'b0, ovf_out}, 32'd0);
        @(negedge clk_in);
        @(posedge clk_in);
        #3 rst_in = 1'b0;
        out_ready_in = 1'b1;
        #1 check("t6_ready", {31'b0, ready_out}, 32'd1);
        align();
        send_beat(pack4(16'h0800, 16'h0, 16'h0, 16'h0), pack4(16'h0600, 16'h0, 16'h0, 16'h0),
                  16'h0, 1'b0, 1'b1);
        idle();
        wait_result("t6_fresh", 16'h0C00, 1'b0);
        repeat (6) @(negedge clk_in);
        check("t6_no_extra_valid", {31'b0, valid_out}, 32'd0);
        check("t6_no_extra_pending", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
